pm1_bist: RTL and testbench
===========================

# pm1_bist

Self-test harness stage wrapped around the mapped `pm1_comb` netlist, which is purely combinational. It sits directly upstream and downstream of that netlist. A 16-bit LFSR generates the input pattern that drives the netlist's 16 input pads. A 16-bit MISR compacts its 13 output pads every cycle. A small FSM sequences a fixed-length run and reports a pass/fail signature, so the mapped netlist can be checked against a golden signature after each mapper flow.

## Interface
- `PATTERNS`, default 1024: number of vectors applied per run; legal range 1..65535.
- `LFSR_SEED`, default 16'hACE1: LFSR load value; must be nonzero.
- `MISR_INIT`, default 16'h0000: MISR load value.
- `GOLDEN`, default 16'h0000: expected final signature.
- Clocking and reset (already decided): one clock; reset is synchronous and active-low.
- `clk_pad`  in  1  sole clock; all state updates on its rising edge.
- `rst_n_pad`  in  1  synchronous active-low reset.
- `start_pad`  in  1  level-sampled run request.
- `pat_pad`  out  16  pattern to the netlist.
  - Bit order 0..15 maps to pads a, b, c, d, e, g, h, i, j, k, l, m, n, o, p, q.
  - Driven directly from the LFSR register.
- `resp_pad`  in  13  netlist response.
  - Bit order 0..12 maps to pads a0, b0, c0, d0, r, s, t, u, v, w, x, y, z.
- `busy_pad`  out  1  high in RUN.
- `done_pad`  out  1  high in DONE.
- `sig_pad`  out  16  current MISR contents.
- `pass_pad`  out  1  `done_pad & (sig_pad == GOLDEN)`.

## Operation
- **State registers:** `lfsr[15:0]`, `misr[15:0]`, `cnt` (16 bits), FSM state.
- **FSM states:** IDLE, RUN, DONE.
- **LFSR step:** `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
- **MISR step:** `misr <= {misr[14:0], misr[15]^misr[14]^misr[12]^misr[3]} ^ {3'b000, resp_pad}`.
- **IDLE:**
  - Hold `lfsr = LFSR_SEED`, `misr = MISR_INIT`, `cnt = 0`.
  - `start_pad = 1` moves to RUN on the next edge.
- **RUN, every edge:**
  - MISR step (absorbs the response to the current `pat_pad`).
  - LFSR step.
  - `cnt <= cnt + 1`.
  - If `cnt == PATTERNS-1` on that edge, go to DONE. That edge still absorbs the last response and steps the LFSR.
  - `start_pad` is ignored.
- **DONE:**
  - `lfsr`, `misr` and `cnt` are frozen.
  - `start_pad = 1` reloads seed, init and `cnt = 0`, and enters RUN on the same edge (back-to-back runs).
  - `start_pad = 0` stays in DONE indefinitely.
- **Reset (`rst_n_pad = 0` at an edge), in any state including mid-RUN:**
  - State goes to IDLE; `lfsr = LFSR_SEED`, `misr = MISR_INIT`, `cnt = 0`.
  - Reset dominates `start_pad`.
- **Outputs:** `busy_pad`, `done_pad` and `pass_pad` are decoded from state/`misr` registers only; there is no combinational path from `start_pad` or `resp_pad` to any output.

## Timing
- **Reset values:**
  - `pat_pad = LFSR_SEED`.
  - `sig_pad = MISR_INIT`.
  - `busy_pad = 0`, `done_pad = 0`, `pass_pad = 0`.
- **Start latency:** `start_pad` high at edge E puts `busy_pad` high after E. Pattern 0 (the seed) is presented in the cycle after E.
- **Response capture:** the netlist is combinational, so `resp_pad` is sampled on the same edge that retires the pattern on `pat_pad`. There is no pipeline stage between the two.
- **Run length:** exactly `PATTERNS` RUN cycles. `done_pad` rises `PATTERNS` edges after entering RUN; `busy_pad` falls on that same edge.
- **Pass output:** `pass_pad` is valid from the first DONE cycle onward.
- **Counter width:** `cnt` is 16 bits, and `PATTERNS-1` fits in it. Wrap is never reached.

## Test plan
- Reset, then hold `start_pad = 0` for 10 cycles: `pat_pad = 16'hACE1`, `sig_pad = 16'h0000`, `busy_pad = 0`, `done_pad = 0` throughout.
- Pattern sequence (`PATTERNS = 4`): pulse start, then check `pat_pad` on consecutive RUN cycles: 16'hACE1, then 16'h59C3. `busy_pad` is high for exactly 4 cycles, then `done_pad = 1`.
- MISR arithmetic (`PATTERNS = 2`, `resp_pad` tied to 13'h0001, `MISR_INIT = 0`):
  - Final `sig_pad = 16'h0003`.
  - With `GOLDEN = 16'h0003`: `pass_pad = 1`. With `GOLDEN = 16'h0004`: `pass_pad = 0`.
- Full loop with the `pm1_comb` netlist attached (`PATTERNS = 1024`): final `sig_pad` equals the signature from a reference model of the same Boolean functions, and `pass_pad = 1` with that value as `GOLDEN`.
- Mid-run reset (`PATTERNS = 8`): assert `rst_n_pad` low at RUN cycle 3. The next cycle shows IDLE values; restarting yields a signature identical to an uninterrupted run.
- Back-to-back runs:
  - Hold `start_pad = 1` across DONE: a second run starts with `pat_pad = 16'hACE1` and gives an identical signature.
  - Toggling `start_pad` during RUN changes neither the run length nor the signature.

Source files
------------

// File: rtl/pm1_bist.sv
// pm1_bist: built-in self-test wrapper for the combinational pm1_comb netlist.
//
// A 16-bit LFSR drives the netlist's 16 input pads. A 16-bit MISR compacts
// the netlist's 13 output pads on every RUN cycle. A three-state FSM
// (IDLE -> RUN -> DONE) applies exactly PATTERNS vectors. It then exposes the
// final signature and compares it against GOLDEN.
//
// Parameters:
//   PATTERNS   vectors per run, 1..65535
//   LFSR_SEED  LFSR load value (nonzero)
//   MISR_INIT  MISR load value
//   GOLDEN     expected final signature
//
// Ports:
//   clk_pad    in   1   clock, rising edge
//   rst_n_pad  in   1   synchronous active-low reset
//   start_pad  in   1   level-sampled run request (ignored while running)
//   pat_pad    out  16  pattern to the netlist, straight from the LFSR register
//   resp_pad   in   13  netlist response to the pattern currently on pat_pad
//   busy_pad   out  1   high while in RUN
//   done_pad   out  1   high while in DONE
//   sig_pad    out  16  current MISR contents
//   pass_pad   out  1   DONE and signature equals GOLDEN
module pm1_bist #(
    parameter int unsigned PATTERNS  = 1024,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] MISR_INIT = 16'h0000,
    parameter logic [15:0] GOLDEN    = 16'h0000
) (
    input  logic        clk_pad,
    input  logic        rst_n_pad,
    input  logic        start_pad,
    output logic [15:0] pat_pad,
    input  logic [12:0] resp_pad,
    output logic        busy_pad,
    output logic        done_pad,
    output logic [15:0] sig_pad,
    output logic        pass_pad
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(PATTERNS - 1);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] cnt_q, cnt_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [12:0] r);
        return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {3'b000, r};
    endfunction

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                lfsr_d = LFSR_SEED;
                misr_d = MISR_INIT;
                cnt_d  = 16'd0;
                if (start_pad) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The response sampled here belongs to the pattern being
                // retired on this same edge; the netlist adds no latency.
                misr_d = misr_step(misr_q, resp_pad);
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Reload and enter RUN on the same edge so that runs can be
                // issued back-to-back without passing through IDLE.
                if (start_pad) begin
                    lfsr_d  = LFSR_SEED;
                    misr_d  = MISR_INIT;
                    cnt_d   = 16'd0;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pad) begin
        if (!rst_n_pad) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= MISR_INIT;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pat_pad  = lfsr_q;
    assign sig_pad  = misr_q;
    assign busy_pad = (state_q == S_RUN);
    assign done_pad = (state_q == S_DONE);
    assign pass_pad = (state_q == S_DONE) && (misr_q == GOLDEN);

endmodule

// File: tb/tb_pm1_bist.sv
// Testbench for pm1_bist. A behavioural stand-in for the pm1_comb netlist
// (resp_of) closes the loop. Expected patterns and signatures are queued
// when a run is launched and are consumed as the DUT presents them.
module tb_pm1_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] pat_q[$];
    logic [15:0] sig_q[$];

    // Stand-in Boolean functions for the mapped netlist
    function automatic logic [12:0] resp_of(input logic [15:0] p);
        return p[12:0] ^ (p[15:3] & p[14:2]);
    endfunction

    function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return (l << 1) | {15'd0, fb};
    endfunction

    function automatic logic [15:0] sig_model(input int n, input bit comb, input logic [12:0] tied);
        logic [15:0] l;
        logic [15:0] m;
        logic [12:0] r;
        logic        fb;
        l = 16'hACE1;
        m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            r  = comb ? resp_of(l) : tied;
            fb = m[15] ^ m[14] ^ m[12] ^ m[3];
            m  = ((m << 1) | {15'd0, fb}) ^ {3'b000, r};
            l  = lfsr_nx(l);
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pats(input int n);
        logic [15:0] l;
        l = 16'hACE1;
        pat_q.delete();
        for (int i = 0; i < n; i++) begin
            pat_q.push_back(l);
            l = lfsr_nx(l);
        end
    endtask

    // ---------------- DUT with PATTERNS = 4 ----------------
    logic        rst4 = 1'b0, start4 = 1'b0;
    logic [15:0] pat4, sig4;
    logic [12:0] resp4;
    logic        busy4, done4, pass4;
    assign resp4 = resp_of(pat4);
    pm1_bist #(.PATTERNS(4)) u_dut4 (
        .clk_pad(clk), .rst_n_pad(rst4), .start_pad(start4), .pat_pad(pat4),
        .resp_pad(resp4), .busy_pad(busy4), .done_pad(done4), .sig_pad(sig4),
        .pass_pad(pass4));

    // ---------------- DUTs with PATTERNS = 2, tied response ----------------
    logic        rst2 = 1'b0, start2 = 1'b0;
    logic [15:0] pat2a, sig2a, pat2b, sig2b;
    logic        busy2a, done2a, pass2a, busy2b, done2b, pass2b;
    pm1_bist #(.PATTERNS(2), .GOLDEN(16'h0003)) u_dut2a (
        .clk_pad(clk), .rst_n_pad(rst2), .start_pad(start2), .pat_pad(pat2a),
        .resp_pad(13'h0001), .busy_pad(busy2a), .done_pad(done2a), .sig_pad(sig2a),
        .pass_pad(pass2a));
    pm1_bist #(.PATTERNS(2), .GOLDEN(16'h0004)) u_dut2b (
        .clk_pad(clk), .rst_n_pad(rst2), .start_pad(start2), .pat_pad(pat2b),
        .resp_pad(13'h0001), .busy_pad(busy2b), .done_pad(done2b), .sig_pad(sig2b),
        .pass_pad(pass2b));

    // ---------------- DUT with PATTERNS = 8 ----------------
    logic        rst8 = 1'b0, start8 = 1'b0;
    logic [15:0] pat8, sig8;
    logic [12:0] resp8;
    logic        busy8, done8, pass8;
    assign resp8 = resp_of(pat8);
    pm1_bist #(.PATTERNS(8)) u_dut8 (
        .clk_pad(clk), .rst_n_pad(rst8), .start_pad(start8), .pat_pad(pat8),
        .resp_pad(resp8), .busy_pad(busy8), .done_pad(done8), .sig_pad(sig8),
        .pass_pad(pass8));

    // ---------------- DUT with PATTERNS = 1024 ----------------
    logic        rstk = 1'b0, startk = 1'b0;
    logic [15:0] patk, sigk;
    logic [12:0] respk;
    logic        busyk, donek, passk;
    assign respk = resp_of(patk);
    pm1_bist #(.PATTERNS(1024)) u_dutk (
        .clk_pad(clk), .rst_n_pad(rstk), .start_pad(startk), .pat_pad(patk),
        .resp_pad(respk), .busy_pad(busyk), .done_pad(donek), .sig_pad(sigk),
        .pass_pad(passk));

    // Consume a PATTERNS=8 run; optionally toggle start every cycle
    task automatic run8(input bit toggle, output int len);
        len = 0;
        while (busy8 && len < 100) begin
            if (pat_q.size() > 0) chk("pat8", pat8, pat_q.pop_front());
            if (toggle) start8 = ~start8;
            len++;
            step();
        end
    endtask

    initial begin
        int          len;
        logic [15:0] e;

        // Reset state and idle hold
        step(); step();
        chk("rst_pat4", pat4, 16'hACE1);
        chk("rst_sig4", sig4, 16'h0000);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_done4", done4, 1'b0);
        chk("rst_pass4", pass4, 1'b0);
        rst4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_pat4", pat4, 16'hACE1);
            chk("idle_sig4", sig4, 16'h0000);
            chk("idle_busy4", busy4, 1'b0);
            chk("idle_done4", done4, 1'b0);
        end

        // Pattern sequence, PATTERNS = 4
        start4 = 1'b1;
        push_pats(4);
        sig_q.push_back(sig_model(4, 1'b1, 13'h0));
        step();
        start4 = 1'b0;
        chk("pat4_second", 32'(lfsr_nx(16'hACE1)), 32'h59C3);
        len = 0;
        while (busy4 && len < 20) begin
            if (pat_q.size() > 0) chk("pat4", pat4, pat_q.pop_front());
            len++;
            step();
        end
        chk("busy4_len", len, 4);
        chk("done4", done4, 1'b1);
        e = sig_q.pop_front();
        chk("sig4", sig4, e);
        chk("pass4", pass4, e == 16'h0000);
        step();
        chk("done4_hold", done4, 1'b1);
        chk("sig4_hold", sig4, e);

        // MISR arithmetic, PATTERNS = 2, response tied to 1
        rst2 = 1'b1;
        step();
        start2 = 1'b1;
        sig_q.push_back(16'h0003);
        step();
        start2 = 1'b0;
        chk("pass2_during_run", pass2a, 1'b0);
        len = 0;
        while (!done2a && len < 20) begin
            len++;
            step();
        end
        chk("len2", len, 2);
        e = sig_q.pop_front();
        chk("sig2a", sig2a, e);
        chk("sig2a_model", sig2a, sig_model(2, 1'b0, 13'h0001));
        chk("sig2b", sig2b, e);
        chk("pass2a", pass2a, 1'b1);
        chk("pass2b", pass2b, 1'b0);

        // Mid-run reset, PATTERNS = 8
        rst8 = 1'b1;
        step();
        start8 = 1'b1;
        push_pats(8);
        step();
        start8 = 1'b0;
        step(); step(); step();
        chk("pat8_cyc3", pat8, pat_q[3]);
        rst8 = 1'b0;
        step();
        pat_q.delete();
        chk("mrst_pat8", pat8, 16'hACE1);
        chk("mrst_sig8", sig8, 16'h0000);
        chk("mrst_busy8", busy8, 1'b0);
        chk("mrst_done8", done8, 1'b0);
        rst8 = 1'b1;
        step();
        chk("mrst_idle_busy8", busy8, 1'b0);
        start8 = 1'b1;
        push_pats(8);
        sig_q.push_back(sig_model(8, 1'b1, 13'h0));
        step();
        start8 = 1'b0;
        run8(1'b0, len);
        chk("len8_restart", len, 8);
        chk("sig8_restart", sig8, sig_q.pop_front());

        // Start toggling during RUN; start then held across DONE
        start8 = 1'b1;
        push_pats(8);
        sig_q.push_back(sig_model(8, 1'b1, 13'h0));
        step();
        run8(1'b1, len);
        chk("len8_toggle", len, 8);
        chk("done8_toggle", done8, 1'b1);
        chk("sig8_toggle", sig8, sig_q.pop_front());
        start8 = 1'b1;
        push_pats(8);
        sig_q.push_back(sig_model(8, 1'b1, 13'h0));
        step();
        chk("b2b_busy8", busy8, 1'b1);
        chk("b2b_pat8", pat8, 16'hACE1);
        run8(1'b0, len);
        chk("len8_b2b", len, 8);
        chk("sig8_b2b", sig8, sig_q.pop_front());
        start8 = 1'b0;
        step();
        chk("done8_stay", done8, 1'b1);

        // Full loop, PATTERNS = 1024
        rstk = 1'b1;
        step();
        startk = 1'b1;
        push_pats(1024);
        sig_q.push_back(sig_model(1024, 1'b1, 13'h0));
        step();
        startk = 1'b0;
        len = 0;
        while (busyk && len < 1100) begin
            if (pat_q.size() > 0) chk("patk", patk, pat_q.pop_front());
            len++;
            step();
        end
        chk("lenk", len, 1024);
        chk("donek", donek, 1'b1);
        e = sig_q.pop_front();
        chk("sigk", sigk, e);
        chk("passk", passk, e == 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
